// File: rtl/conv_layer_sequencer.sv
// Control sequencer for the conv_layer MAC datapath: walks the forward or
// kernel-gradient loop nest, one MAC term per cycle, with a valid/ready result port.
module conv_layer_sequencer #(
    parameter int NUM_KERNELS      = 2,
    parameter int KERNEL_DIM       = 3,
    parameter int INPUT_DIM_WIDTH  = 3,
    parameter int INPUT_DIM_HEIGHT = 3,
    parameter int AW               = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] img_row,
    output logic [AW-1:0] img_col,
    output logic [AW-1:0] kern_idx,
    output logic [AW-1:0] kern_row,
    output logic [AW-1:0] kern_col,
    output logic [AW-1:0] err_row,
    output logic [AW-1:0] err_col,
    output logic          mac_clear,
    output logic          mac_en,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_kern,
    output logic [AW-1:0] res_row,
    output logic [AW-1:0] res_col
);

    localparam int OW      = INPUT_DIM_WIDTH - KERNEL_DIM + 1;
    localparam int OH      = INPUT_DIM_HEIGHT - KERNEL_DIM + 1;
    localparam int MAX_DIM = (32'sd1 <<< AW) - 32'sd1;

    localparam logic [AW-1:0] KD_LAST = AW'(KERNEL_DIM - 1);
    localparam logic [AW-1:0] OW_LAST = AW'(OW - 1);
    localparam logic [AW-1:0] OH_LAST = AW'(OH - 1);
    localparam logic [AW-1:0] KN_LAST = AW'(NUM_KERNELS - 1);
    localparam logic [AW-1:0] ZERO    = {AW{1'b0}};

    if ((KERNEL_DIM > INPUT_DIM_WIDTH) || (KERNEL_DIM > INPUT_DIM_HEIGHT)) begin : g_kd_too_big
        $error("conv_layer_sequencer: KERNEL_DIM exceeds the input image size");
    end
    if ((NUM_KERNELS > MAX_DIM) || (KERNEL_DIM > MAX_DIM) ||
        (INPUT_DIM_WIDTH > MAX_DIM) || (INPUT_DIM_HEIGHT > MAX_DIM)) begin : g_dim_too_big
        $error("conv_layer_sequencer: a dimension does not fit in AW-bit indices");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t        state_r, state_next_s;
    logic          mode_r, mode_next_s;
    logic [AW-1:0] k_r, r_r, c_r, i_r, j_r;
    logic [AW-1:0] k_next_s, r_next_s, c_next_s, i_next_s, j_next_s;
    logic          last_term_s, last_tuple_s;

    logic          busy_r, done_r, mac_clear_r, mac_en_r, res_valid_r;
    logic [AW-1:0] img_row_r, img_col_r, kern_idx_r, kern_row_r, kern_col_r;
    logic [AW-1:0] err_row_r, err_col_r, res_kern_r, res_row_r, res_col_r;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] v, input logic [AW-1:0] last);
        if (v == last) begin
            return {AW{1'b0}};
        end else begin
            return v + AW'(1);
        end
    endfunction

    // Next-state and loop-counter advance; mode selects which counters are inner
    always_comb begin
        state_next_s = state_r;
        mode_next_s  = mode_r;
        k_next_s     = k_r;
        r_next_s     = r_r;
        c_next_s     = c_r;
        i_next_s     = i_r;
        j_next_s     = j_r;
        last_term_s  = 1'b0;
        last_tuple_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_CLEAR;
                    mode_next_s  = mode;
                    k_next_s     = ZERO;
                    r_next_s     = ZERO;
                    c_next_s     = ZERO;
                    i_next_s     = ZERO;
                    j_next_s     = ZERO;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_next_s = ST_ACC;
            end
            ST_ACC: begin
                if (mode_r) begin
                    c_next_s    = wrap_inc(c_r, OW_LAST);
                    r_next_s    = (c_r == OW_LAST) ? wrap_inc(r_r, OH_LAST) : r_r;
                    last_term_s = (c_r == OW_LAST) && (r_r == OH_LAST);
                end else begin
                    j_next_s    = wrap_inc(j_r, KD_LAST);
                    i_next_s    = (j_r == KD_LAST) ? wrap_inc(i_r, KD_LAST) : i_r;
                    last_term_s = (j_r == KD_LAST) && (i_r == KD_LAST);
                end
                if (last_term_s) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_ACC;
                end
            end
            ST_WRITE: begin
                if (res_ready) begin
                    // The carry out of the kernel counter marks the final result
                    if (mode_r) begin
                        j_next_s     = wrap_inc(j_r, KD_LAST);
                        i_next_s     = (j_r == KD_LAST) ? wrap_inc(i_r, KD_LAST) : i_r;
                        k_next_s     = ((j_r == KD_LAST) && (i_r == KD_LAST)) ?
                                       wrap_inc(k_r, KN_LAST) : k_r;
                        last_tuple_s = (j_r == KD_LAST) && (i_r == KD_LAST) && (k_r == KN_LAST);
                    end else begin
                        c_next_s     = wrap_inc(c_r, OW_LAST);
                        r_next_s     = (c_r == OW_LAST) ? wrap_inc(r_r, OH_LAST) : r_r;
                        k_next_s     = ((c_r == OW_LAST) && (r_r == OH_LAST)) ?
                                       wrap_inc(k_r, KN_LAST) : k_r;
                        last_tuple_s = (c_r == OW_LAST) && (r_r == OH_LAST) && (k_r == KN_LAST);
                    end
                    if (last_tuple_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_CLEAR;
                    end
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, latched mode and loop counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            mode_r  <= 1'b0;
            k_r     <= ZERO;
            r_r     <= ZERO;
            c_r     <= ZERO;
            i_r     <= ZERO;
            j_r     <= ZERO;
        end else begin
            state_r <= state_next_s;
            mode_r  <= mode_next_s;
            k_r     <= k_next_s;
            r_r     <= r_next_s;
            c_r     <= c_next_s;
            i_r     <= i_next_s;
            j_r     <= j_next_s;
        end
    end

    // Strobes and result tags registered from the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mac_clear_r <= 1'b0;
            mac_en_r    <= 1'b0;
            res_valid_r <= 1'b0;
            res_kern_r  <= ZERO;
            res_row_r   <= ZERO;
            res_col_r   <= ZERO;
        end else begin
            busy_r      <= (state_next_s != ST_IDLE);
            done_r      <= (state_next_s == ST_DONE);
            mac_clear_r <= (state_next_s == ST_CLEAR);
            mac_en_r    <= (state_next_s == ST_ACC);
            res_valid_r <= (state_next_s == ST_WRITE);
            if (state_next_s == ST_WRITE) begin
                res_kern_r <= k_next_s;
                res_row_r  <= mode_r ? i_next_s : r_next_s;
                res_col_r  <= mode_r ? j_next_s : c_next_s;
            end else begin
                res_kern_r <= ZERO;
                res_row_r  <= ZERO;
                res_col_r  <= ZERO;
            end
        end
    end

    // Datapath indices track the term being accumulated and hold otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            img_row_r  <= ZERO;
            img_col_r  <= ZERO;
            kern_idx_r <= ZERO;
            kern_row_r <= ZERO;
            kern_col_r <= ZERO;
            err_row_r  <= ZERO;
            err_col_r  <= ZERO;
        end else if (state_next_s == ST_ACC) begin
            img_row_r  <= r_next_s + i_next_s;
            img_col_r  <= c_next_s + j_next_s;
            kern_idx_r <= k_next_s;
            kern_row_r <= i_next_s;
            kern_col_r <= j_next_s;
            err_row_r  <= r_next_s;
            err_col_r  <= c_next_s;
        end else begin
            img_row_r  <= img_row_r;
            img_col_r  <= img_col_r;
            kern_idx_r <= kern_idx_r;
            kern_row_r <= kern_row_r;
            kern_col_r <= kern_col_r;
            err_row_r  <= err_row_r;
            err_col_r  <= err_col_r;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign mac_clear = mac_clear_r;
    assign mac_en    = mac_en_r;
    assign res_valid = res_valid_r;
    assign res_kern  = res_kern_r;
    assign res_row   = res_row_r;
    assign res_col   = res_col_r;
    assign img_row   = img_row_r;
    assign img_col   = img_col_r;
    assign kern_idx  = kern_idx_r;
    assign kern_row  = kern_row_r;
    assign kern_col  = kern_col_r;
    assign err_row   = err_row_r;
    assign err_col   = err_col_r;

endmodule
